// File: rtl/rand_draw.sv
// rand_draw: on a debounced key press, draws one value from a free-running random
// stream, rejecting out-of-range values and (optionally) recent repeats.
//
//   state | meaning
//   IDLE  | waiting for synchronized key high
//   DEB   | counting consecutive high samples of the key
//   DRAW  | examining rnd each cycle until accept or try budget spent
//   REL   | draw finished; waiting for key release
module rand_draw #(
  parameter int RANGE      = 100,
  parameter int DEB_CYCLES = 16,
  parameter int HIST_DEPTH = 4,
  parameter int NOREP      = 1,
  parameter int TRY_MAX    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rnd,
  input  logic       key,
  input  logic       clr,
  output logic [7:0] draw_val,
  output logic       done,
  output logic       err,
  output logic [7:0] count,
  output logic       busy,
  output logic [6:0] ten,
  output logic [6:0] one
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_DRAW, S_REL} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_key_meta, r_key_s;
  logic [DW-1:0]   r_deb_cnt, w_deb_nxt;
  logic [7:0]      r_tries, w_tries_nxt;
  logic [7:0]      r_draw_val, r_count;
  logic            r_done, r_err;
  logic [7:0]      r_hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] r_hist_v;
  logic            w_match, w_in_range, w_accept, w_deb_last, w_try_last;
  logic            w_take, w_fail, w_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
    end else begin
      r_key_meta <= key;
      r_key_s    <= r_key_meta;
    end
  end

  // Invalid history slots never match, so a fresh or cleared history accepts anything.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++)
      if (r_hist_v[i] && (r_hist[i] == rnd)) w_match = 1'b1;
  end

  assign w_in_range = ({1'b0, rnd} < 9'(RANGE));
  assign w_accept   = w_in_range && !((NOREP != 0) && w_match);
  assign w_deb_last = ((int'(r_deb_cnt) + 1) >= DEB_CYCLES);
  assign w_try_last = (r_tries == 8'(TRY_MAX - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_tries_nxt = r_tries;
    w_take      = 1'b0;
    w_fail      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_key_s) begin
          if (DEB_CYCLES <= 1) begin
            w_state_nxt = S_DRAW;
            w_tries_nxt = 8'd0;
          end else begin
            w_state_nxt = S_DEB;
            w_deb_nxt   = DW'(1);
          end
        end
      end
      S_DEB: begin
        w_busy = 1'b1;
        if (!r_key_s) begin
          w_state_nxt = S_IDLE;
        end else if (w_deb_last) begin
          w_state_nxt = S_DRAW;
          w_tries_nxt = 8'd0;
        end else begin
          w_deb_nxt = r_deb_cnt + DW'(1);
        end
      end
      S_DRAW: begin
        w_busy = 1'b1;
        if (w_accept) begin
          w_take      = 1'b1;
          w_state_nxt = S_REL;
        end else if (w_try_last) begin
          w_fail      = 1'b1;
          w_state_nxt = S_REL;
        end else begin
          w_tries_nxt = r_tries + 8'd1;
        end
      end
      S_REL: begin
        if (!r_key_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_tries   <= 8'd0;
    end else if (clr) begin
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_tries   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_tries   <= w_tries_nxt;
    end
  end

  // clr overrides an accept landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_draw_val <= 8'd0;
      r_count    <= 8'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hist_v   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 8'd0;
    end else if (clr) begin
      r_draw_val <= 8'd0;
      r_count    <= 8'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hist_v   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 8'd0;
    end else begin
      r_done <= w_take;
      if (w_take) begin
        r_draw_val <= rnd;
        r_count    <= r_count + 8'd1;
        r_err      <= 1'b0;
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
          r_hist[i]   <= r_hist[i-1];
          r_hist_v[i] <= r_hist_v[i-1];
        end
        r_hist[0]   <= rnd;
        r_hist_v[0] <= 1'b1;
      end else if (w_fail) begin
        r_err <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] trsltr(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign draw_val = r_draw_val;
  assign done     = r_done;
  assign err      = r_err;
  assign count    = r_count;
  assign busy     = w_busy;
  assign ten      = trsltr(r_draw_val[7:4]);
  assign one      = trsltr(r_draw_val[3:0]);

endmodule

// File: tb/tb_rand_draw.sv
// Self-checking bench for rand_draw: two instances (repeat rejection on/off) share
// stimulus; directed table, bounce, reset, clr, wrap and randomized presses.
module tb_rand_draw;

  localparam int RANGE = 100;
  localparam int DEB   = 16;
  localparam int TRYM  = 8;
  localparam int HD    = 4;

  typedef logic [7:0][7:0] vals_t;
  typedef struct {
    vals_t v;
    int    ia, va, ca;
    int    ib, vb, cb;
  } vec_t;

  logic clk = 1'b0;
  logic reset, key, clr;
  logic [7:0] rnd;
  logic [7:0] dv_a, dv_b, cnt_a, cnt_b;
  logic done_a, done_b, err_a, err_b, busy_a, busy_b;
  logic [6:0] ten_a, one_a, ten_b, one_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nd[2]    = '{0, 0};
  int ldc[2]   = '{0, 0};

  int mh[2][HD];
  int mhn[2];
  int mval[2], mcnt[2], merr[2];
  int mnorep[2] = '{1, 0};

  always #5 clk = ~clk;

  rand_draw #(.RANGE(RANGE), .DEB_CYCLES(DEB), .HIST_DEPTH(HD), .NOREP(1), .TRY_MAX(TRYM)) u_a (
    .clk(clk), .reset(reset), .rnd(rnd), .key(key), .clr(clr),
    .draw_val(dv_a), .done(done_a), .err(err_a), .count(cnt_a), .busy(busy_a),
    .ten(ten_a), .one(one_a));

  rand_draw #(.RANGE(RANGE), .DEB_CYCLES(DEB), .HIST_DEPTH(HD), .NOREP(0), .TRY_MAX(TRYM)) u_b (
    .clk(clk), .reset(reset), .rnd(rnd), .key(key), .clr(clr),
    .draw_val(dv_b), .done(done_b), .err(err_b), .count(cnt_b), .busy(busy_b),
    .ten(ten_b), .one(one_b));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) begin nd[0] <= nd[0] + 1; ldc[0] <= cyc; end
    if (done_b) begin nd[1] <= nd[1] + 1; ldc[1] <= cyc; end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[d];
  endfunction

  function automatic vals_t mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    vals_t v;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2); v[3] = 8'(a3);
    v[4] = 8'(a4); v[5] = 8'(a5); v[6] = 8'(a6); v[7] = 8'(a7);
    return v;
  endfunction

  function automatic vals_t fill8(input int a);
    return mk8(a, a, a, a, a, a, a, a);
  endfunction

  function automatic int g_dv(input int i);   return (i == 0) ? int'(dv_a)   : int'(dv_b);   endfunction
  function automatic int g_cnt(input int i);  return (i == 0) ? int'(cnt_a)  : int'(cnt_b);  endfunction
  function automatic int g_err(input int i);  return (i == 0) ? int'(err_a)  : int'(err_b);  endfunction
  function automatic int g_busy(input int i); return (i == 0) ? int'(busy_a) : int'(busy_b); endfunction
  function automatic int g_ten(input int i);  return (i == 0) ? int'(ten_a)  : int'(ten_b);  endfunction
  function automatic int g_one(input int i);  return (i == 0) ? int'(one_a)  : int'(one_b);  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: first candidate that is in range and (if enabled) not recently drawn.
  function automatic int m_idx(input int i, input vals_t v);
    bit rep;
    for (int k = 0; k < TRYM; k++) begin
      rep = 1'b0;
      for (int j = 0; j < mhn[i]; j++) if (mh[i][j] == int'(v[k])) rep = 1'b1;
      if (int'(v[k]) < RANGE && !(mnorep[i] == 1 && rep)) return k;
    end
    return -1;
  endfunction

  task automatic m_apply(input int i, input vals_t v, input int idx);
    if (idx >= 0) begin
      mval[i] = int'(v[idx]);
      mcnt[i] = (mcnt[i] + 1) % 256;
      merr[i] = 0;
      for (int j = HD - 1; j > 0; j--) mh[i][j] = mh[i][j-1];
      mh[i][0] = int'(v[idx]);
      if (mhn[i] < HD) mhn[i]++;
    end else begin
      merr[i] = 1;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      mval[i] = 0; mcnt[i] = 0; merr[i] = 0; mhn[i] = 0;
      for (int j = 0; j < HD; j++) mh[i][j] = 0;
    end
  endtask

  task automatic chk_state(input string tag, input int i, input int ev, input int ec, input int ee);
    chk({tag, "_val"},   g_dv(i),  ev);
    chk({tag, "_count"}, g_cnt(i), ec);
    chk({tag, "_err"},   g_err(i), ee);
    chk({tag, "_ten"},   g_ten(i), int'(seg(4'(ev >> 4))));
    chk({tag, "_one"},   g_one(i), int'(seg(4'(ev & 15))));
  endtask

  // One key press; rnd supplies v[k] on the k-th DRAW cycle.
  task automatic run_press(input string tag, input vals_t v,
                           input int eidx[2], input int ev[2], input int ec[2]);
    int c0;
    int nd0[2];
    @(negedge clk);
    nd0[0] = nd[0]; nd0[1] = nd[1];
    c0  = cyc;
    key = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    for (int k = 0; k < TRYM; k++) begin
      #1 rnd = v[k];
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ndone"}, nd[i] - nd0[i], (eidx[i] >= 0) ? 1 : 0);
      if (eidx[i] >= 0) chk({tag, "_latency"}, ldc[i] - c0, DEB + 3 + eidx[i]);
      chk_state(tag, i, ev[i], ec[i], (eidx[i] < 0) ? 1 : 0);
      chk({tag, "_busy_rel"}, g_busy(i), 0);
    end
    key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_press(input string tag, input vals_t v);
    int ei[2], ev[2], ec[2];
    for (int i = 0; i < 2; i++) begin
      ei[i] = m_idx(i, v);
      m_apply(i, v, ei[i]);
      ev[i] = mval[i];
      ec[i] = mcnt[i];
    end
    run_press(tag, v, ei, ev, ec);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vals_t v;
    int ei[2], ev[2], ec[2];
    int nd0[2];

    tbl[0] = '{mk8(200, 150, 100, 37, 37, 37, 37, 37), 3, 37, 1, 3, 37, 1};
    tbl[1] = '{mk8(37, 12, 12, 12, 12, 12, 12, 12),    1, 12, 2, 0, 37, 2};
    tbl[2] = '{fill8(255),                             -1, 12, 2, -1, 37, 2};
    tbl[3] = '{fill8(5),                               0, 5, 3, 0, 5, 3};
    tbl[4] = '{mk8(99, 100, 1, 1, 1, 1, 1, 1),         0, 99, 4, 0, 99, 4};
    tbl[5] = '{mk8(37, 12, 5, 99, 42, 42, 42, 42),     4, 42, 5, 0, 37, 5};
    tbl[6] = '{fill8(37),                              0, 37, 6, 0, 37, 6};

    reset = 1'b0; key = 1'b0; clr = 1'b0; rnd = 8'd0;
    m_clear();
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_state("reset", i, 0, 0, 0);
      chk("reset_busy", g_busy(i), 0);
    end
    chk("reset_done", int'(done_a | done_b), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      ei = '{tbl[r].ia, tbl[r].ib};
      ev = '{tbl[r].va, tbl[r].vb};
      ec = '{tbl[r].ca, tbl[r].cb};
      run_press($sformatf("tbl%0d", r), tbl[r].v, ei, ev, ec);
      m_apply(0, tbl[r].v, tbl[r].ia);
      m_apply(1, tbl[r].v, tbl[r].ib);
    end

    // Bouncing key: never 16 consecutive highs, so no draw until held steady.
    @(negedge clk);
    nd0[0] = nd[0]; nd0[1] = nd[1];
    rnd = 8'd77;
    for (int b = 0; b < 4; b++) begin
      key = 1'b1;
      repeat (5) @(negedge clk);
      key = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("bounce_nodone_a", nd[0] - nd0[0], 0);
    chk("bounce_nodone_b", nd[1] - nd0[1], 0);
    key = 1'b1;
    repeat (26) @(negedge clk);
    #1;
    v = fill8(77);
    for (int i = 0; i < 2; i++) begin
      m_apply(i, v, m_idx(i, v));
      chk("steady_ndone", nd[i] - nd0[i], 1);
      chk_state("steady", i, mval[i], mcnt[i], merr[i]);
    end
    key = 1'b0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      int sel;
      for (int k = 0; k < TRYM; k++) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: v[k] = 8'($urandom_range(0, 255));
          1: v[k] = 8'(mh[0][$urandom_range(0, HD - 1)]);
          2: v[k] = 8'd255;
          default: v[k] = 8'($urandom_range(0, RANGE - 1));
        endcase
      end
      if ($urandom_range(0, 7) == 0) v = fill8(200);
      model_press($sformatf("rnd%0d", n), v);
    end

    // Async reset in the middle of DRAW.
    @(negedge clk);
    key = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #1 rnd = 8'd255;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("draw_busy_a", int'(busy_a), 1);
    chk("draw_busy_b", int'(busy_b), 1);
    reset = 1'b0;
    key   = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_state("midrst", i, 0, 0, 0);
      chk("midrst_busy", g_busy(i), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    repeat (3) @(negedge clk);

    for (int n = 0; n < 256; n++) model_press($sformatf("wrap%0d", n), fill8((n * 7) % 100));
    chk("wrap_count_a", int'(cnt_a), 0);
    chk("wrap_count_b", int'(cnt_b), 0);

    // clr on the same edge as an accepting candidate.
    @(negedge clk);
    nd0[0] = nd[0]; nd0[1] = nd[1];
    key = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #1 rnd = 8'd50;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    key = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    m_clear();
    for (int i = 0; i < 2; i++) begin
      chk("clr_ndone", nd[i] - nd0[i], 0);
      chk_state("clr", i, 0, 0, 0);
      chk("clr_busy", g_busy(i), 0);
    end
    model_press("postclr", fill8(85));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
